// File: rtl/clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// clock_time_ctrl
//   Time-of-day source for the seven-segment clock display. Keeps hh:mm:ss as
//   six packed BCD digits, advances on a 1 Hz enable, and lets the user set
//   hours / minutes / seconds with two debounced push-buttons.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous active-high reset
//   tick       : one-cycle 1 Hz enable, synchronous to clk
//   btn_mode   : raw mode button (asynchronous, active-high)
//   btn_inc    : raw increment button (asynchronous, active-high)
//   time_bcd   : {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}, 4-bit BCD each
//   les        : per-digit blink mask, same digit order as time_bcd
//   set_active : high while in any SET state
//   sec_wrap   : one-cycle pulse when the time rolls 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module clock_time_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [23:0] time_bcd,
  output logic [5:0]  les,
  output logic        set_active,
  output logic        sec_wrap
);

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_SEC} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Button conditioning: bit 0 = mode, bit 1 = increment.
  // -------------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       sync1, sync2;
  logic [1:0]       deb;
  logic [1:0]       pulse;
  logic [CNT_W-1:0] cnt [2];
  logic             mode_p, inc_p;

  assign btn_raw = {btn_inc, btn_mode};
  assign mode_p  = pulse[0];
  assign inc_p   = pulse[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      pulse <= '0;
      for (int b = 0; b < 2; b++) cnt[b] <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples the
      // pre-edge values; blocking here would chain sync1 straight into sync2.
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        pulse[b] <= 1'b0;
        if (sync2[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          // Level held long enough: accept it; a rising acceptance is the press.
          deb[b]   <= sync2[b];
          pulse[b] <= sync2[b];
          cnt[b]   <= '0;
        end else begin
          cnt[b] <= cnt[b] + CNT_ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Mode FSM: state register / next-state / registered outputs.
  // -------------------------------------------------------------------------
  state_t state, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state;
    if (mode_p) begin
      unique case (state)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself.
  logic [5:0] les_d;
  logic       set_active_d;

  always_comb begin
    les_d = 6'b000000;
    unique case (state_d)
      SET_HR:  les_d = 6'b110000;
      SET_MIN: les_d = 6'b001100;
      SET_SEC: les_d = 6'b000011;
      default: les_d = 6'b000000;
    endcase
    set_active_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      les        <= '0;
      set_active <= 1'b0;
    end else begin
      les        <= les_d;
      set_active <= set_active_d;
    end
  end

  // -------------------------------------------------------------------------
  // Time datapath: three two-digit BCD fields.
  // -------------------------------------------------------------------------
  logic [7:0] hh, mm, ss;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] max);
    if (v == max)            return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh       <= 8'h00;
      mm       <= 8'h00;
      ss       <= 8'h00;
      sec_wrap <= 1'b0;
    end else begin
      sec_wrap <= 1'b0;
      if (state == RUN) begin
        // A tick coinciding with mode_p is still applied here.
        if (tick) begin
          ss <= inc_bcd(ss, 8'h59);
          if (ss == 8'h59) begin
            mm <= inc_bcd(mm, 8'h59);
            if (mm == 8'h59) begin
              hh <= inc_bcd(hh, 8'h23);
              if (hh == 8'h23) sec_wrap <= 1'b1;
            end
          end
        end
      end else if (inc_p && !mode_p) begin
        // Mode wins over a coincident increment; fields never carry in set.
        unique case (state)
          SET_HR:  hh <= inc_bcd(hh, 8'h23);
          SET_MIN: mm <= inc_bcd(mm, 8'h59);
          SET_SEC: ss <= inc_bcd(ss, 8'h59);
          default: ;
        endcase
      end
    end
  end

  assign time_bcd = {hh, mm, ss};

endmodule

// File: tb/tb_clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_time_ctrl
//   Self-checking bench for clock_time_ctrl (DEBOUNCE_CYCLES = 4). The
//   reference model keeps the time as integer hours/minutes/seconds and the
//   mode as an index 0..3 (RUN, SET_HR, SET_MIN, SET_SEC).
// ---------------------------------------------------------------------------
module tb_clock_time_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] time_bcd;
  logic [5:0]  les;
  logic        set_active;
  logic        sec_wrap;

  int checks = 0;
  int errors = 0;

  // Reference model
  int m_h = 0, m_m = 0, m_s = 0, m_st = 0;

  clock_time_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .time_bcd   (time_bcd),
    .les        (les),
    .set_active (set_active),
    .sec_wrap   (sec_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_time();
    return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
            4'(m_s / 10), 4'(m_s % 10)};
  endfunction

  function automatic logic [5:0] exp_les();
    case (m_st)
      1:       return 6'b110000;
      2:       return 6'b001100;
      3:       return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic advance();
    int total;
    total = ((m_h * 3600 + m_m * 60 + m_s) + 1) % 86400;
    m_h = total / 3600;
    m_m = (total / 60) % 60;
    m_s = total % 60;
  endtask

  // Tick n times, checking time and the wrap pulse after each one.
  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      bit wrap;
      wrap = 1'b0;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      if (m_st == 0) begin
        wrap = (m_h == 23 && m_m == 59 && m_s == 59);
        advance();
      end
      checks++;
      if (time_bcd !== exp_time()) begin
        errors++;
        $display("FAIL tick_time: got %h expected %h", time_bcd, exp_time());
      end
      checks++;
      if (sec_wrap !== wrap) begin
        errors++;
        $display("FAIL tick_sec_wrap: got %b expected %b", sec_wrap, wrap);
      end
    end
  endtask

  // Clean press of the selected buttons; optional tick lands in the same
  // cycle as the debounced pulse (2 + DEB cycles after the press).
  task automatic press(input bit m, input bit i, input bit t);
    @(negedge clk); btn_mode = m; btn_inc = i;
    repeat (2 + DEB) @(negedge clk);
    tick = t;
    @(negedge clk); tick = 1'b0;
    if (m) begin
      if (m_st == 0 && t) advance();
      m_st = (m_st + 1) % 4;
    end else if (i) begin
      case (m_st)
        1:       m_h = (m_h + 1) % 24;
        2:       m_m = (m_m + 1) % 60;
        3:       m_s = (m_s + 1) % 60;
        default: ;
      endcase
    end else if (t && m_st == 0) begin
      advance();
    end
    checks++;
    if (time_bcd !== exp_time()) begin
      errors++;
      $display("FAIL press_time: got %h expected %h", time_bcd, exp_time());
    end
    checks++;
    if (les !== exp_les()) begin
      errors++;
      $display("FAIL press_les: got %b expected %b", les, exp_les());
    end
    checks++;
    if (set_active !== (m_st != 0)) begin
      errors++;
      $display("FAIL press_set_active: got %b expected %b", set_active, (m_st != 0));
    end
    // Keep holding: no auto-repeat may occur.
    repeat (3) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    checks++;
    if (time_bcd !== exp_time() || les !== exp_les()) begin
      errors++;
      $display("FAIL hold_release: got %h/%b expected %h/%b",
               time_bcd, les, exp_time(), exp_les());
    end
  endtask

  task automatic goto_st(input int target);
    while (m_st != target) press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_time(input int h, input int mn, input int s);
    goto_st(1); while (m_h != h)  press(1'b0, 1'b1, 1'b0);
    goto_st(2); while (m_m != mn) press(1'b0, 1'b1, 1'b0);
    goto_st(3); while (m_s != s)  press(1'b0, 1'b1, 1'b0);
    goto_st(0);
  endtask

  // Raise rst mid-cycle and check outputs clear before any clock edge.
  task automatic apply_reset_async();
    @(negedge clk); #2 rst = 1'b1; #1;
    m_h = 0; m_m = 0; m_s = 0; m_st = 0;
    checks++;
    if (time_bcd !== 24'h000000 || les !== 6'b0 || set_active !== 1'b0 || sec_wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b/%b expected 000000/000000/0/0",
               time_bcd, les, set_active, sec_wrap);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (time_bcd !== 24'h000000 || les !== 6'b0 || set_active !== 1'b0 || sec_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b/%b/%b expected 000000/000000/0/0",
               time_bcd, les, set_active, sec_wrap);
    end
    rst = 1'b0;
    do_tick(10);
    checks++;
    if (time_bcd !== 24'h000010) begin
      errors++;
      $display("FAIL ten_ticks: got %h expected 000010", time_bcd);
    end
    apply_reset_async();
  endtask

  task automatic test_wrap();
    set_time(23, 59, 58);
    do_tick(1);
    checks++;
    if (time_bcd !== 24'h235959) begin
      errors++;
      $display("FAIL pre_wrap: got %h expected 235959", time_bcd);
    end
    do_tick(1);
    checks++;
    if (time_bcd !== 24'h000000 || sec_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got %h/%b expected 000000/1", time_bcd, sec_wrap);
    end
    @(negedge clk);
    checks++;
    if (sec_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_width: got %b expected 0", sec_wrap);
    end
    apply_reset_async();
    set_time(0, 9, 59);
    do_tick(1);
    checks++;
    if (time_bcd !== 24'h001000) begin
      errors++;
      $display("FAIL minute_carry: got %h expected 001000", time_bcd);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    int n;
    seen = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      btn_mode = ((k / 2) % 2 == 0);
      @(negedge clk);
      if (les !== 6'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bounce_no_pulse: got les change expected none");
    end
    btn_mode = 1'b1;
    n = 0;
    while (les === 6'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    m_st = 1;
    checks++;
    if (n != 2 + DEB + 1) begin
      errors++;
      $display("FAIL bounce_latency: got %0d cycles expected %0d", n, 2 + DEB + 1);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (les !== 6'b110000 || set_active !== 1'b1) begin
      errors++;
      $display("FAIL bounce_state: got %b/%b expected 110000/1", les, set_active);
    end
    btn_mode = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic test_set_fields();
    while (m_h != 22) press(1'b0, 1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (time_bcd[23:16] !== 8'h01) begin
      errors++;
      $display("FAIL hour_wrap: got %h expected 01", time_bcd[23:16]);
    end
    do_tick(5);
    press(1'b1, 1'b0, 1'b0);
    while (m_m != 59) press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (time_bcd[15:8] !== 8'h00 || time_bcd[23:16] !== 8'h01) begin
      errors++;
      $display("FAIL min_wrap: got %h expected 0100xx", time_bcd);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    do_tick(1);
  endtask

  task automatic test_simultaneous();
    goto_st(3);
    press(1'b1, 1'b1, 1'b0);
    goto_st(3);
    press(1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b1);
    goto_st(0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      do_tick($urandom_range(1, 3));
      else if (r < 7) press(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      else            press(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_set();
    goto_st(2);
    press(1'b0, 1'b1, 1'b0);
    apply_reset_async();
    do_tick(1);
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_bounce();
    test_set_fields();
    test_simultaneous();
    test_random();
    test_reset_mid_set();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Upstream time source for the seven-segment clock display: holds hh:mm:ss as six packed BCD digits and advances it on an external 1 Hz enable.
- Adds a user set mode driven by two raw push-buttons (mode, increment).
- Exports the BCD time word plus a per-digit blink mask; the display stage places these on the hh/mm/ss digit positions of the 8-digit serial display and the 4-digit AN/SEGMENT display.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed before a button level is accepted (10 ms at 100 MHz); benches override to 4.
CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
tick  input  1  one-cycle enable at 1 Hz, synchronous to clk
btn_mode  input  1  raw mode button, active-high, asynchronous
btn_inc  input  1  raw increment button, active-high, asynchronous
time_bcd  output  24  {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}, 4 bits each, BCD
les  output  6  blink mask, one bit per digit, same order as time_bcd
set_active  output  1  high when in any SET state
sec_wrap  output  1  one-cycle pulse when time rolls 23:59:59 -> 00:00:00 in RUN

Behaviour:
- Reset (async, rst=1): time_bcd=24'h000000, state=RUN, les=0, set_active=0, sec_wrap=0, synchronizers, debounce counters and debounced levels all 0. Reset asserted mid-set aborts the set; the partially edited time is discarded.
- Button path, per button:
  - 2-FF synchronizer.
  - Counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A 0->1 flip of the debounced level gives a one-cycle pulse (mode_p / inc_p).
  - Latency from a clean press to pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Holding a button gives exactly one pulse; there is no auto-repeat.
- FSM states: RUN, SET_HR, SET_MIN, SET_SEC.
  - mode_p steps RUN->SET_HR->SET_MIN->SET_SEC->RUN; no other transitions.
- RUN:
  - tick increments ss with BCD carry: ss_u 9->0 carries to ss_t; ss 59->00 carries to mm; mm 59->00 carries to hh; hh 23->00.
  - sec_wrap=1 in the cycle after the 23:59:59 -> 00:00:00 update registers.
  - inc_p is ignored.
- SET_x:
  - tick ignored; time frozen.
  - inc_p increments only the selected field: hours 23->00, minutes and seconds 59->00.
  - No carry into other fields; sec_wrap stays 0.
- Simultaneous events:
  - mode_p with inc_p in a SET state: mode wins, inc dropped.
  - tick with mode_p in RUN: tick increment applied and state moves to SET_HR in the same edge.
  - tick with mode_p in SET_SEC: state returns to RUN, tick is not applied.
- Outputs, all registered, updating one cycle after the causing edge:
  - les = 6'b110000 in SET_HR, 6'b001100 in SET_MIN, 6'b000011 in SET_SEC, 0 in RUN.
  - set_active = (state != RUN).
- Digits never hold a non-BCD value. Out-of-range input is impossible, since time is loaded only by reset.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then 10 ticks -> time_bcd=24'h000010. Assert rst mid-run for 1 cycle -> time_bcd=0, les=0 immediately, without waiting for a clk edge.
- Run from 23:59:58: 2 ticks -> 23:59:59 then 24'h000000; sec_wrap high exactly 1 cycle. Also check 00:09:59 -> 00:10:00 on the next tick.
- Bounce: btn_mode toggles every 2 cycles for 20 cycles, then held high -> exactly one mode_p; state SET_HR, les=6'b110000, set_active=1. Count cycles from stable high to les change = 2+4+1.
- SET_HR at 22:xx:xx: 3 inc presses -> hh=23, 00, 01 with mm/ss unchanged. 5 ticks during set -> time unchanged.
- SET_MIN at mm=59: 1 inc -> mm=00 and hh unchanged. Mode x2 -> back to RUN, les=0; next tick advances ss.
- Same-cycle mode and inc in SET_SEC -> state RUN, ss unchanged. Same-cycle tick and mode in RUN -> ss+1 and state SET_HR.
